ball_mover: RTL and testbench
=============================

# ball_mover

Ball position engine for the pong datapath. Holds the ball's 3-bit x/y coordinates on the 8x8 field and steps them once per game tick in the direction chosen by the direction calculator (`cal_vector`). It feeds `x_pos`/`y_pos` back to that block and consumes its `out_x`/`out_y`/`endgame`. It also owns the IDLE/RUN/OVER game-flow state machine and the tick divider.

## Interface
- `TICK_DIV`, default 25000000: clock cycles per ball step; must be ≥ 2.
- `CNT_W`, default 25: tick counter width; must satisfy 2^CNT_W ≥ TICK_DIV.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: level-sampled launch/restart request.
- `dir_x` in 1: x direction from `cal_vector` `out_x`. 0 = increment, 1 = decrement.
- `dir_y` in 1: y direction from `cal_vector` `out_y`. 0 = increment, 1 = decrement.
- `endgame_in` in 1: miss indication from `cal_vector` `endgame`.
- `x_pos` out 3: ball column, registered.
- `y_pos` out 3: ball row, registered.
- `running` out 1: high while in RUN.
- `game_over` out 1: high while in OVER.
- `tick` out 1: one-cycle pulse in the cycle after each step.

## Operation
- Reset (`rst`=1 at an edge):
  - state=IDLE, `x_pos`=3, `y_pos`=3.
  - counter=0, `tick`=0, `running`=0, `game_over`=0.
  - `rst` overrides every other input.
- IDLE:
  - Position holds; counter held at 0.
  - `start`=1 → RUN with counter=0.
- RUN:
  - Counter increments each cycle.
  - When counter==TICK_DIV-1 (step edge), counter→0 and the step below executes.
  - Game-over check first: if `endgame_in`=1, or `y_pos`==0, or `y_pos`==7 → OVER. Position is not moved on that edge.
  - Otherwise x and y each move by ±1 per their direction bit.
  - No wrap-around: a step that would take a coordinate below 0 or above 7 leaves it saturated at 0 or 7.
  - `start` is ignored in RUN.
- OVER:
  - Position and counter hold; `game_over`=1.
  - `start`=1 → IDLE with `x_pos`=3, `y_pos`=3, counter=0, `game_over`=0.
- `running` and `game_over` are decoded from registered state, so they are glitch-free and mutually exclusive.
- Unused state encodings recover to IDLE on the next edge.

## Timing
- `dir_x`, `dir_y` and `endgame_in` are sampled only at the step edge. `cal_vector` is combinational from `x_pos`/`y_pos`, so its inputs are stable a full cycle before that edge.
- Step spacing: exactly TICK_DIV cycles. First step occurs TICK_DIV edges after the edge that sampled `start`.
- `tick` is high for exactly the cycle following each step edge, including a step edge that enters OVER. `tick` is never high in IDLE.
- State transition latency: one edge from the `start` sample to RUN/IDLE; one edge from the step edge to OVER.
- `rst` asserted mid-RUN: the next edge gives IDLE, (3,3), counter 0, `tick` 0. This holds even if that edge would have been a step edge.

## Test plan
- Reset, then hold `start`=0 for 20 cycles → `x_pos`=3, `y_pos`=3, `running`=0, `game_over`=0, `tick`=0 throughout.
- TICK_DIV=4, `start` pulse, `dir_x`=0, `dir_y`=0 → (4,4) after 4 cycles, (5,5) after 8; `tick` pulses once every 4 cycles.
- Reach x=7 with `dir_x`=0 held, `dir_y` toggling to keep y in 2..5 → `x_pos` stays 7 and never wraps to 0.
- RUN at (2,3), `endgame_in`=1 at the step edge → OVER, position stays (2,3), `game_over`=1. Then `start` → IDLE at (3,3), `game_over`=0.
- `dir_y`=0 from y=5 → step to y=6, then 7. At the next step edge → OVER with `y_pos`=7.
- `rst` asserted in RUN with counter=2 → next cycle IDLE, (3,3), no `tick`. A fresh `start` restarts full 4-cycle spacing.

Source files
------------

// File: rtl/ball_mover.sv
// Ball position engine for the pong datapath.
// Holds the ball's x/y coordinates on the 8x8 field and runs the tick divider.
// Steps the ball once per game tick and owns the IDLE/RUN/OVER game flow.
module ball_mover #(
    parameter int TICK_DIV = 25000000,
    parameter int CNT_W    = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dir_x,
    input  logic       dir_y,
    input  logic       endgame_in,
    output logic [2:0] x_pos,
    output logic [2:0] y_pos,
    output logic       running,
    output logic       game_over,
    output logic       tick
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        OVER = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TICK_DIV - 1);
    localparam logic [2:0]       HOME       = 3'd3;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic             step_edge;
    logic             over_hit;
    logic [2:0]       x_step;
    logic [2:0]       y_step;

    // Step-edge detect, miss/wall detect and saturating next coordinates
    always_comb begin
        step_edge = (state == RUN) && (count == LAST_COUNT);
        over_hit  = endgame_in || (y_pos == 3'd0) || (y_pos == 3'd7);
        if (dir_x) begin
            x_step = (x_pos == 3'd0) ? 3'd0 : x_pos - 3'd1;
        end else begin
            x_step = (x_pos == 3'd7) ? 3'd7 : x_pos + 3'd1;
        end
        if (dir_y) begin
            y_step = (y_pos == 3'd0) ? 3'd0 : y_pos - 3'd1;
        end else begin
            y_step = (y_pos == 3'd7) ? 3'd7 : y_pos + 3'd1;
        end
    end

    // Game-flow state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; any unused encoding falls back to IDLE
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE: state_next = start ? RUN : IDLE;
            RUN:  state_next = (step_edge && over_hit) ? OVER : RUN;
            OVER: state_next = start ? IDLE : OVER;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the registered state only
    always_comb begin
        running   = (state == RUN);
        game_over = (state == OVER);
    end

    // Tick divider, ball position and the tick pulse following each step edge
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            x_pos <= HOME;
            y_pos <= HOME;
            tick  <= 1'b0;
        end else begin
            tick <= step_edge;
            case (state)
                IDLE: begin
                    count <= '0;
                end
                RUN: begin
                    if (step_edge) begin
                        count <= '0;
                        if (!over_hit) begin
                            x_pos <= x_step;
                            y_pos <= y_step;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                OVER: begin
                    if (start) begin
                        count <= '0;
                        x_pos <= HOME;
                        y_pos <= HOME;
                    end
                end
                default: begin
                    count <= '0;
                    x_pos <= HOME;
                    y_pos <= HOME;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ball_mover.sv
// Testbench for ball_mover with a small tick divider.
// A behavioural game model predicts position, status and tick every cycle.
module tb_ball_mover;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       dir_x = 1'b0;
    logic       dir_y = 1'b0;
    logic       endgame_in = 1'b0;
    logic [2:0] x_pos;
    logic [2:0] y_pos;
    logic       running;
    logic       game_over;
    logic       tick;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Behavioural model: mode 0 = idle, 1 = running, 2 = over
    int m_mode = 0;
    int m_x = 3;
    int m_y = 3;
    int m_phase = 0;
    int m_tick = 0;

    ball_mover #(.TICK_DIV(TD), .CNT_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dir_x(dir_x),
        .dir_y(dir_y),
        .endgame_in(endgame_in),
        .x_pos(x_pos),
        .y_pos(y_pos),
        .running(running),
        .game_over(game_over),
        .tick(tick)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic logic [8:0] model_vec();
        return {3'(m_x), 3'(m_y), (m_mode == 1), (m_mode == 2), (m_tick == 1)};
    endfunction

    function automatic logic [8:0] dut_vec();
        return {x_pos, y_pos, running, game_over, tick};
    endfunction

    // Apply inputs for one clock edge, advance the model, settle past the edge
    task automatic drive_cycle(input logic r, input logic s, input logic dx,
                               input logic dy, input logic eg);
        rst = r; start = s; dir_x = dx; dir_y = dy; endgame_in = eg;
        @(posedge clk);
        cyc++;
        if (r) begin
            m_mode = 0; m_x = 3; m_y = 3; m_phase = 0; m_tick = 0;
        end else begin
            m_tick = 0;
            if (m_mode == 0) begin
                if (s) begin m_mode = 1; m_phase = 0; end
            end else if (m_mode == 1) begin
                m_phase++;
                if (m_phase == TD) begin
                    m_phase = 0;
                    m_tick = 1;
                    if (eg || m_y == 0 || m_y == 7) begin
                        m_mode = 2;
                    end else begin
                        m_x = m_x + (dx ? -1 : 1);
                        m_y = m_y + (dy ? -1 : 1);
                        if (m_x < 0) m_x = 0;
                        if (m_x > 7) m_x = 7;
                        if (m_y < 0) m_y = 0;
                        if (m_y > 7) m_y = 7;
                    end
                end
            end else begin
                if (s) begin m_mode = 0; m_x = 3; m_y = 3; end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (dut_vec() !== {3'd3, 3'd3, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL reset_state got=%h want=%h", dut_vec(), {3'd3, 3'd3, 3'b000});
        end
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            total++;
            if (dut_vec() !== {3'd3, 3'd3, 3'b000} || dut_vec() !== model_vec()) begin
                bad++;
                $display("[TB] FAIL idle_hold cycle=%0d got=%h want=%h", cyc, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_basic_steps();
        int ticks = 0;
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (tick) ticks++;
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("[TB] FAIL basic_model cycle=%0d got=%h want=%h", cyc, dut_vec(), model_vec());
            end
            if (i == 4) begin
                total++;
                if ({x_pos, y_pos, tick} !== {3'd4, 3'd4, 1'b1}) begin
                    bad++;
                    $display("[TB] FAIL first_step got=%0d,%0d tick=%b want=4,4 tick=1", x_pos, y_pos, tick);
                end
            end
            if (i == 8) begin
                total++;
                if ({x_pos, y_pos, tick} !== {3'd5, 3'd5, 1'b1}) begin
                    bad++;
                    $display("[TB] FAIL second_step got=%0d,%0d tick=%b want=5,5 tick=1", x_pos, y_pos, tick);
                end
            end
        end
        total++;
        if (ticks != 2) begin
            bad++;
            $display("[TB] FAIL tick_count got=%0d want=2", ticks);
        end
    endtask

    task automatic test_x_saturate();
        logic seen_wrap = 1'b0;
        for (int i = 0; i < 6 * TD; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b0, (m_y >= 4), 1'b0);
            if (m_x == 7 && x_pos !== 3'd7) seen_wrap = 1'b1;
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("[TB] FAIL xsat_model cycle=%0d got=%h want=%h", cyc, dut_vec(), model_vec());
            end
        end
        total++;
        if (x_pos !== 3'd7 || seen_wrap || running !== 1'b1) begin
            bad++;
            $display("[TB] FAIL x_saturate got x=%0d run=%b wrap=%b want x=7 run=1 wrap=0", x_pos, running, seen_wrap);
        end
    endtask

    task automatic test_endgame();
        logic [5:0] dxs = 6'b001111;
        logic [5:0] dys = 6'b101010;
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int s = 0; s < 6; s++) begin
            for (int c = 0; c < TD; c++) begin
                drive_cycle(1'b0, 1'b0, dxs[s], dys[s], 1'b0);
                total++;
                if (dut_vec() !== model_vec()) begin
                    bad++;
                    $display("[TB] FAIL path_model cycle=%0d got=%h want=%h", cyc, dut_vec(), model_vec());
                end
            end
        end
        total++;
        if ({x_pos, y_pos} !== {3'd2, 3'd3}) begin
            bad++;
            $display("[TB] FAIL reach_2_3 got=%0d,%0d want=2,3", x_pos, y_pos);
        end
        for (int c = 0; c < TD; c++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (dut_vec() !== {3'd2, 3'd3, 1'b0, 1'b1, 1'b1} || dut_vec() !== model_vec()) begin
            bad++;
            $display("[TB] FAIL endgame_over got=%h want=%h", dut_vec(), {3'd2, 3'd3, 3'b011});
        end
        for (int c = 0; c < 5; c++) drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        total++;
        if (dut_vec() !== {3'd2, 3'd3, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL over_hold got=%h want=%h", dut_vec(), {3'd2, 3'd3, 3'b010});
        end
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (dut_vec() !== {3'd3, 3'd3, 3'b000}) begin
            bad++;
            $display("[TB] FAIL over_to_idle got=%h want=%h", dut_vec(), {3'd3, 3'd3, 3'b000});
        end
    endtask

    task automatic test_top_wall();
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < TD; c++) begin
                drive_cycle(1'b0, 1'b0, 1'(s % 2), 1'b0, 1'b0);
                total++;
                if (dut_vec() !== model_vec()) begin
                    bad++;
                    $display("[TB] FAIL wall_model cycle=%0d got=%h want=%h", cyc, dut_vec(), model_vec());
                end
            end
        end
        total++;
        if (y_pos !== 3'd7 || game_over !== 1'b1 || running !== 1'b0) begin
            bad++;
            $display("[TB] FAIL top_wall got y=%0d over=%b run=%b want y=7 over=1 run=0", y_pos, game_over, running);
        end
    endtask

    task automatic test_mid_run_reset();
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (dut_vec() !== {3'd3, 3'd3, 3'b000}) begin
            bad++;
            $display("[TB] FAIL reset_mid_run got=%h want=%h", dut_vec(), {3'd3, 3'd3, 3'b000});
        end
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < TD - 1; c++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (dut_vec() !== {3'd3, 3'd3, 3'b000}) begin
            bad++;
            $display("[TB] FAIL reset_on_step got=%h want=%h", dut_vec(), {3'd3, 3'd3, 3'b000});
        end
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= TD; c++) begin
            drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            total++;
            if (tick !== (c == TD) || dut_vec() !== model_vec()) begin
                bad++;
                $display("[TB] FAIL restart_spacing c=%0d got=%h want=%h", c, dut_vec(), model_vec());
            end
        end
        total++;
        if ({x_pos, y_pos} !== {3'd2, 3'd2}) begin
            bad++;
            $display("[TB] FAIL restart_step got=%0d,%0d want=2,2", x_pos, y_pos);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 9) == 0));
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("[TB] FAIL random cycle=%0d got=%h want=%h", cyc, dut_vec(), model_vec());
            end
        end
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_basic_steps();
        test_x_saturate();
        test_endgame();
        test_top_wall();
        test_mid_run_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
